// File: rtl/regbank_v2_pkg.sv
// regbank_v2 shared definitions: register map,
// CONTROL bit positions and the bank ID byte.
package regbank_v2_pkg;

  localparam logic [7:0] ADDR_MACRO_ADDR  = 8'h00;
  localparam logic [7:0] ADDR_MACRO_DATA  = 8'h01;
  localparam logic [7:0] ADDR_MACRO_RDSEL = 8'h02;
  localparam logic [7:0] ADDR_CONTROL     = 8'h03;
  localparam logic [7:0] ADDR_SPI_ADDR    = 8'h04;
  localparam logic [7:0] ADDR_MACRO_WRSEL = 8'h05;
  localparam logic [7:0] ADDR_MACRO_INFO  = 8'h06;
  localparam logic [7:0] ADDR_PERF0       = 8'h07;
  localparam logic [7:0] ADDR_PERF1       = 8'h08;
  localparam logic [7:0] ADDR_PERF2       = 8'h09;
  localparam logic [7:0] ADDR_PERF3       = 8'h0A;
  localparam logic [7:0] ADDR_INT_STATUS  = 8'h0B;
  localparam logic [7:0] ADDR_INT_MASK    = 8'h0C;

  localparam int READBACK_BIT = 7;

  localparam int CTRL_HASH_EN  = 0;
  localparam int CTRL_AUTO_INC = 1;
  localparam int CTRL_PERF_RUN = 2;
  localparam int CTRL_LED      = 3;
  localparam int CTRL_HCLK_RST = 4;
  localparam int CTRL_ID       = 5;
  localparam int CTRL_PERF_CLR = 6;

  localparam logic [7:0] REGBANK_ID = 8'h12;

endpackage

// File: rtl/regbank_v2_sync_2ff.sv
// regbank_v2 two-flop synchroniser, parametrised width,
// async active-low reset.
module regbank_v2_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/regbank_v2.sv
// regbank_v2: SPI-clock register bank for the hash-macro array.
// Optional perf counter: define REGBANK_PERF_COUNTER_EN.
module regbank_v2
  import regbank_v2_pkg::*;
#(
  parameter int NUM_MACROS       = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 8,
  parameter int MACRO_ADDR_WIDTH = 6,
  parameter int PERF_WIDTH       = 32
) (
  input  logic                        SPI_CLK,
  input  logic                        RST_S1_N,
  input  logic [ADDR_WIDTH-1:0]       address,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        read_strobe,
  input  logic                        write_strobe,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        LED_out,
  output logic                        ID_out,
  output logic                        hash_clock_reset,
  output logic [6:0]                  spi_addr,
  output logic                        interrupt_out,
  output logic                        HASH_EN,
  output logic [NUM_MACROS-1:0]       MACRO_WR_SELECT,
  output logic [NUM_MACROS-1:0]       MACRO_RD_SELECT,
  output logic                        MACRO_WR_STROBE,
  output logic [DATA_WIDTH-1:0]       DATA_TO_HASH,
  output logic [MACRO_ADDR_WIDTH-1:0] HASH_ADDR,
  input  logic [3:0]                  THREAD_COUNT,
  input  logic [NUM_MACROS-1:0]       DATA_AVAILABLE,
  input  logic [DATA_WIDTH-1:0]       DATA_FROM_HASH
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int MW = MACRO_ADDR_WIDTH;

`ifdef REGBANK_PERF_COUNTER_EN
  localparam logic [DW-1:0] CTRL_WMASK = DW'(8'h3F);
`else
  localparam logic [DW-1:0] CTRL_WMASK = DW'(8'h3B);
`endif

  logic [DW-1:0]         r_macro_addr;
  logic [DW-1:0]         r_macro_data;
  logic [NUM_MACROS-1:0] r_rd_sel;
  logic [NUM_MACROS-1:0] r_wr_sel;
  logic [DW-1:0]         r_control;
  logic [DW-1:0]         r_spi_addr;
  logic [NUM_MACROS-1:0] r_int_status;
  logic [DW-1:0]         r_int_mask;
  logic [NUM_MACROS-1:0] r_da_prev;
  logic                  r_wr_stb;
  logic                  r_inc_pend;
  logic [DW-1:0]         r_data_out;

  logic [NUM_MACROS-1:0] w_da_sync;
  logic [NUM_MACROS-1:0] w_da_rise;
  logic [NUM_MACROS-1:0] w_ist_clr;
  logic [DW-1:0]         w_dfh_sync;
  logic [DW-1:0]         w_rd_data;
  logic [DW-1:0]         w_maddr_inc;
  logic [DW-1:0]         w_perf_b0;
  logic [23:0]           w_snap;

  logic w_sel_rb, w_sel_maddr, w_sel_mdata, w_sel_rdsel;
  logic w_sel_ctrl, w_sel_spi, w_sel_wrsel, w_sel_info;
  logic w_sel_p0, w_sel_p1, w_sel_p2, w_sel_p3;
  logic w_sel_ist, w_sel_imask;

  regbank_v2_sync_2ff #(.WIDTH(NUM_MACROS)) u_sync_da (
    .i_clk   (SPI_CLK),
    .i_rst_n (RST_S1_N),
    .i_d     (DATA_AVAILABLE),
    .o_q     (w_da_sync)
  );

  regbank_v2_sync_2ff #(.WIDTH(DW)) u_sync_dfh (
    .i_clk   (SPI_CLK),
    .i_rst_n (RST_S1_N),
    .i_d     (DATA_FROM_HASH),
    .o_q     (w_dfh_sync)
  );

  assign w_sel_rb    = address[READBACK_BIT];
  assign w_sel_maddr = address == AW'(ADDR_MACRO_ADDR);
  assign w_sel_mdata = address == AW'(ADDR_MACRO_DATA);
  assign w_sel_rdsel = address == AW'(ADDR_MACRO_RDSEL);
  assign w_sel_ctrl  = address == AW'(ADDR_CONTROL);
  assign w_sel_spi   = address == AW'(ADDR_SPI_ADDR);
  assign w_sel_wrsel = address == AW'(ADDR_MACRO_WRSEL);
  assign w_sel_info  = address == AW'(ADDR_MACRO_INFO);
  assign w_sel_p0    = address == AW'(ADDR_PERF0);
  assign w_sel_p1    = address == AW'(ADDR_PERF1);
  assign w_sel_p2    = address == AW'(ADDR_PERF2);
  assign w_sel_p3    = address == AW'(ADDR_PERF3);
  assign w_sel_ist   = address == AW'(ADDR_INT_STATUS);
  assign w_sel_imask = address == AW'(ADDR_INT_MASK);

  assign w_da_rise = w_da_sync & ~r_da_prev;
  assign w_ist_clr = (write_strobe && w_sel_ist)
                   ? data_in[NUM_MACROS-1:0] : '0;

  // macro address wraps inside the HASH_ADDR field only
  always_comb begin
    w_maddr_inc = r_macro_addr;
    w_maddr_inc[MW-1:0] = r_macro_addr[MW-1:0] + MW'(1);
  end

  // read-data mux, sampled into data_out on read_strobe
  always_comb begin
    w_rd_data = '0;
    unique case (1'b1)
      w_sel_rb:    w_rd_data = w_dfh_sync;
      w_sel_maddr: w_rd_data = r_macro_addr;
      w_sel_rdsel: w_rd_data = DW'(r_rd_sel);
      w_sel_ctrl:  w_rd_data = r_control;
      w_sel_spi:   w_rd_data = r_spi_addr;
      w_sel_wrsel: w_rd_data = DW'(REGBANK_ID);
      w_sel_info:  w_rd_data = DW'({4'(NUM_MACROS),
                                    THREAD_COUNT});
      w_sel_p0:    w_rd_data = w_perf_b0;
      w_sel_p1:    w_rd_data = DW'(w_snap[7:0]);
      w_sel_p2:    w_rd_data = DW'(w_snap[15:8]);
      w_sel_p3:    w_rd_data = DW'(w_snap[23:16]);
      w_sel_ist:   w_rd_data = DW'(r_int_status);
      w_sel_imask: w_rd_data = r_int_mask;
      default:     w_rd_data = '0;
    endcase
  end

  // SPI-written configuration registers
  always_ff @(posedge SPI_CLK or negedge RST_S1_N) begin
    if (!RST_S1_N) begin
      r_macro_data <= '0;
      r_rd_sel     <= '0;
      r_wr_sel     <= '0;
      r_control    <= '0;
      r_spi_addr   <= '0;
      r_int_mask   <= '1;
    end else if (write_strobe) begin
      if (w_sel_mdata) r_macro_data <= data_in;
      if (w_sel_rdsel) r_rd_sel <= data_in[NUM_MACROS-1:0];
      if (w_sel_wrsel) r_wr_sel <= data_in[NUM_MACROS-1:0];
      if (w_sel_ctrl)  r_control <= data_in & CTRL_WMASK;
      if (w_sel_spi)   r_spi_addr <= data_in;
      if (w_sel_imask) r_int_mask <= data_in;
    end
  end

  // macro address, write strobe and deferred auto-increment
  always_ff @(posedge SPI_CLK or negedge RST_S1_N) begin
    if (!RST_S1_N) begin
      r_macro_addr <= '0;
      r_wr_stb     <= 1'b0;
      r_inc_pend   <= 1'b0;
    end else begin
      r_wr_stb   <= write_strobe && w_sel_mdata;
      r_inc_pend <= write_strobe && w_sel_mdata
                 && r_control[CTRL_AUTO_INC];
      if (write_strobe && w_sel_maddr)
        r_macro_addr <= data_in;
      else if (r_inc_pend)
        r_macro_addr <= w_maddr_inc;
    end
  end

  // sticky interrupt status, set beats W1C
  always_ff @(posedge SPI_CLK or negedge RST_S1_N) begin
    if (!RST_S1_N) begin
      r_int_status <= '0;
      r_da_prev    <= '0;
    end else begin
      r_int_status <= (r_int_status & ~w_ist_clr) | w_da_rise;
      r_da_prev    <= w_da_sync;
    end
  end

  // registered read data, held between reads
  always_ff @(posedge SPI_CLK or negedge RST_S1_N) begin
    if (!RST_S1_N)        r_data_out <= '0;
    else if (read_strobe) r_data_out <= w_rd_data;
  end

`ifdef REGBANK_PERF_COUNTER_EN
  logic [PERF_WIDTH-1:0] r_perf;
  logic [23:0]           r_snap;
  logic [31:0]           w_perf32;

  assign w_perf32  = 32'(r_perf);
  assign w_perf_b0 = DW'(w_perf32[7:0]);
  assign w_snap    = r_snap;

  // free-running perf counter, clear beats increment
  always_ff @(posedge SPI_CLK or negedge RST_S1_N) begin
    if (!RST_S1_N)
      r_perf <= '0;
    else if (write_strobe && w_sel_ctrl
             && data_in[CTRL_PERF_CLR])
      r_perf <= '0;
    else if (r_control[CTRL_PERF_RUN])
      r_perf <= r_perf + PERF_WIDTH'(1);
  end

  // upper bytes frozen when byte 0 is read
  always_ff @(posedge SPI_CLK or negedge RST_S1_N) begin
    if (!RST_S1_N)                    r_snap <= '0;
    else if (read_strobe && w_sel_p0) r_snap <= w_perf32[31:8];
  end
`else
  assign w_perf_b0 = DW'(PERF_WIDTH'(0));
  assign w_snap    = '0;
`endif

  assign data_out         = r_data_out;
  assign HASH_EN          = r_control[CTRL_HASH_EN];
  assign LED_out          = r_control[CTRL_LED];
  assign hash_clock_reset = r_control[CTRL_HCLK_RST];
  assign ID_out           = r_control[CTRL_ID];
  assign spi_addr         = r_spi_addr[6:0];
  assign MACRO_WR_SELECT  = r_wr_sel;
  assign MACRO_RD_SELECT  = r_rd_sel;
  assign MACRO_WR_STROBE  = r_wr_stb;
  assign DATA_TO_HASH     = r_macro_data;
  assign HASH_ADDR        = r_macro_addr[MW-1:0];
  assign interrupt_out    =
    |(r_int_status & r_int_mask[NUM_MACROS-1:0]);

endmodule

// File: tb/tb_regbank_v2.sv
// regbank_v2 bench: scoreboarded reads and macro strobes.
// Perf expectations follow REGBANK_PERF_COUNTER_EN.
module tb_regbank_v2;

`ifdef REGBANK_PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] address = '0;
  logic [7:0] data_in = '0;
  logic       read_strobe = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] data_out;
  logic       LED_out, ID_out, hash_clock_reset;
  logic [6:0] spi_addr;
  logic       interrupt_out, HASH_EN;
  logic [3:0] wr_sel, rd_sel;
  logic       wr_stb;
  logic [7:0] data_to_hash;
  logic [5:0] hash_addr;
  logic [3:0] thread_count = 4'h7;
  logic [3:0] data_avail = '0;
  logic [7:0] data_from_hash = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t rd_q[$];
  exp_t st_q[$];
  exp_t rd_e, st_e;
  logic rd_seen = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  regbank_v2 dut (
    .SPI_CLK          (clk),
    .RST_S1_N         (rst_n),
    .address          (address),
    .data_in          (data_in),
    .read_strobe      (read_strobe),
    .write_strobe     (write_strobe),
    .data_out         (data_out),
    .LED_out          (LED_out),
    .ID_out           (ID_out),
    .hash_clock_reset (hash_clock_reset),
    .spi_addr         (spi_addr),
    .interrupt_out    (interrupt_out),
    .HASH_EN          (HASH_EN),
    .MACRO_WR_SELECT  (wr_sel),
    .MACRO_RD_SELECT  (rd_sel),
    .MACRO_WR_STROBE  (wr_stb),
    .DATA_TO_HASH     (data_to_hash),
    .HASH_ADDR        (hash_addr),
    .THREAD_COUNT     (thread_count),
    .DATA_AVAILABLE   (data_avail),
    .DATA_FROM_HASH   (data_from_hash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    write_strobe = 1'b1;
    @(posedge clk);
    #1 write_strobe = 1'b0;
  endtask

  task automatic wr_data(input logic [5:0] ha,
                         input logic [7:0] d);
    st_q.push_back('{{2'b00, ha}, d});
    wr(8'h01, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    @(negedge clk);
    address = a;
    read_strobe = 1'b1;
    rd_q.push_back('{a, e});
    @(posedge clk);
    #1 read_strobe = 1'b0;
  endtask

  always @(posedge clk) rd_seen <= read_strobe;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        rd_e = rd_q.pop_front();
        check($sformatf("rd_%02h", rd_e.a), data_out, rd_e.d);
      end
    end
    if (wr_stb) begin
      if (st_q.size() == 0) begin
        check("strobe_unexpected", 1, 0);
      end else begin
        st_e = st_q.pop_front();
        check("strobe_addr", hash_addr, st_e.a);
        check("strobe_data", data_to_hash, st_e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rst_exp [13];
    rst_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h12, 8'h47, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'hFF};

    repeat (3) @(negedge clk);
    check("rst_strobe", wr_stb, 0);
    check("rst_dout", data_out, 0);
    check("rst_irq", interrupt_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) rd(8'(i), rst_exp[i]);

    wr(8'h03, 8'hFF);
    check("ctl_hash_en", HASH_EN, 1);
    check("ctl_led", LED_out, 1);
    check("ctl_hclk", hash_clock_reset, 1);
    check("ctl_id", ID_out, 1);
    rd(8'h03, PERF ? 8'h3F : 8'h3B);
    wr(8'h03, 8'h00);
    wr(8'h05, 8'hFF);
    check("wr_sel", wr_sel, 4'hF);
    rd(8'h05, 8'h12);
    wr(8'h02, 8'hFA);
    check("rd_sel", rd_sel, 4'hA);
    rd(8'h02, 8'h0A);
    wr(8'h04, 8'hB3);
    check("spi_addr", spi_addr, 7'h33);

    @(negedge clk);
    address = 8'h04;
    data_in = 8'h5C;
    write_strobe = 1'b1;
    read_strobe = 1'b1;
    rd_q.push_back('{8'h04, 8'hB3});
    @(posedge clk);
    #1 write_strobe = 1'b0;
    read_strobe = 1'b0;
    rd(8'h04, 8'h5C);

    wr(8'h03, 8'h02);
    wr(8'h00, 8'h3E);
    wr_data(6'h3E, 8'hA1);
    wr_data(6'h3F, 8'hA2);
    wr_data(6'h00, 8'hA3);
    repeat (2) @(negedge clk);
    rd(8'h00, 8'h01);
    check("dth_final", data_to_hash, 8'hA3);
    rd(8'h01, 8'h00);
    wr(8'h03, 8'h00);
    wr_data(6'h01, 8'h55);
    repeat (2) @(negedge clk);
    rd(8'h00, 8'h01);

    @(negedge clk) data_avail[2] = 1'b1;
    repeat (2) @(negedge clk);
    data_avail[2] = 1'b0;
    repeat (3) @(negedge clk);
    rd(8'h0B, 8'h04);
    check("irq_set", interrupt_out, 1);
    wr(8'h0C, 8'hFB);
    check("irq_masked", interrupt_out, 0);
    rd(8'h0C, 8'hFB);
    wr(8'h0B, 8'h04);
    rd(8'h0B, 8'h00);
    repeat (4) @(negedge clk);
    @(negedge clk) data_avail[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(8'h0B, 8'h04);
    rd(8'h0B, 8'h04);
    data_avail[2] = 1'b0;
    wr(8'h0C, 8'hFF);
    check("irq_unmasked", interrupt_out, 1);
    wr(8'h0B, 8'hFF);
    rd(8'h0B, 8'h00);
    check("irq_cleared", interrupt_out, 0);

    wr(8'h03, 8'h40);
    wr(8'h03, 8'h04);
    repeat (299) @(posedge clk);
    wr(8'h03, 8'h00);
    rd(8'h07, PERF ? 8'h2C : 8'h00);
    rd(8'h08, PERF ? 8'h01 : 8'h00);
    rd(8'h09, 8'h00);
    rd(8'h0A, 8'h00);
    wr(8'h03, 8'h44);
    repeat (767) @(posedge clk);
    rd(8'h07, PERF ? 8'hFF : 8'h00);
    repeat (4) @(posedge clk);
    rd(8'h08, PERF ? 8'h02 : 8'h00);
    rd(8'h03, PERF ? 8'h04 : 8'h00);
    wr(8'h03, 8'h40);
    rd(8'h07, 8'h00);
    rd(8'h08, 8'h00);
    rd(8'h03, 8'h00);

    data_from_hash = 8'h5A;
    repeat (3) @(posedge clk);
    rd(8'h80, 8'h5A);
    data_from_hash = 8'hC3;
    repeat (3) @(posedge clk);
    rd(8'hFF, 8'hC3);
    wr(8'h20, 8'h99);
    rd(8'h20, 8'h00);
    rd(8'h0D, 8'h00);

    wr(8'h03, 8'h3B);
    wr(8'h00, 8'h10);
    wr(8'h05, 8'h03);
    rd(8'h05, 8'h12);
    @(negedge clk);
    address = 8'h01;
    data_in = 8'h77;
    write_strobe = 1'b1;
    @(posedge clk);
    #1 write_strobe = 1'b0;
    check("mid_strobe_hi", wr_stb, 1);
    check("mid_dth", data_to_hash, 8'h77);
    #1 rst_n = 1'b0;
    #1;
    check("rst_strobe_drop", wr_stb, 0);
    check("rst_dth", data_to_hash, 0);
    check("rst_haddr", hash_addr, 0);
    check("rst_dout2", data_out, 0);
    check("rst_ctl_outs",
          {HASH_EN, LED_out, ID_out, hash_clock_reset}, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_spi", spi_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(8'h00, 8'h00);
    rd(8'h03, 8'h00);
    rd(8'h0C, 8'hFF);

    repeat (3) @(negedge clk);
    check("rd_q_empty", rd_q.size(), 0);
    check("st_q_empty", st_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
